// File: rtl/uart_transmitter_if.sv
// Host-side write port of the UART transmitter: byte strobe plus FIFO status.
interface uart_transmitter_if;
  logic       wr_en;
  logic [7:0] din;
  logic       full;
  logic       overflow;
  logic       busy;

  modport master (output wr_en, din, input full, overflow, busy);
  modport slave  (input wr_en, din, output full, overflow, busy);
endinterface

// File: rtl/uart_transmitter.sv
// 8N1/8N2 UART transmitter with a small write FIFO, paced by the shared
// OVERSAMPLE x baud enable; frames go out LSB first, back-to-back while data remains.
module uart_transmitter #(
  parameter int FIFO_DEPTH = 4,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                clk_50m,
  input  logic                rst_n,
  input  logic                clken,
  uart_transmitter_if.slave   host,
  output logic                tx
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, overflow_q;
  logic             wr_ok, pop, fifo_nempty;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [2:0]       bitpos_q, bitpos_d;
  logic             stop_idx_q, stop_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q;

  // Acceptance uses the registered full flag so a write racing a pop is still refused.
  assign wr_ok       = host.wr_en && !full_q;
  assign fifo_nempty = (count_q != '0);

  always_comb begin
    count_d = count_q;
    case ({wr_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q    <= count_d;
      full_q     <= (count_d == CNT_W'(FIFO_DEPTH));
      overflow_q <= host.wr_en && full_q;
    end
  end

  always_ff @(posedge clk_50m) begin
    if (wr_ok) mem[wr_ptr_q] <= host.din;
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bitpos_q   <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitpos_q   <= bitpos_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
    end
  end

  // Everything advances only on baud-enable cycles; pops happen at frame boundaries.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bitpos_d   = bitpos_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    pop        = 1'b0;
    if (clken) begin
      case (state_q)
        IDLE: begin
          if (fifo_nempty) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr_q];
            cnt_d   = '0;
            state_d = START;
          end
        end
        START: begin
          if (cnt_q == TICK_LAST) begin
            cnt_d    = '0;
            bitpos_d = '0;
            state_d  = DATA;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        DATA: begin
          if (cnt_q == TICK_LAST) begin
            cnt_d    = '0;
            shift_d  = shift_q >> 1;
            bitpos_d = bitpos_q + 3'd1;
            if (bitpos_q == 3'd7) begin
              stop_idx_d = 1'b0;
              state_d    = STOP;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        STOP: begin
          if (cnt_q == TICK_LAST) begin
            cnt_d = '0;
            if (stop_idx_q == STOP_LAST) begin
              if (fifo_nempty) begin
                pop     = 1'b1;
                shift_d = mem[rd_ptr_q];
                state_d = START;
              end else begin
                state_d = IDLE;
              end
            end else begin
              stop_idx_d = stop_idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Line driver registered from the current state so tx cannot glitch between bits.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      tx_q <= 1'b1;
    end else begin
      case (state_q)
        START:   tx_q <= 1'b0;
        DATA:    tx_q <= shift_q[0];
        default: tx_q <= 1'b1;
      endcase
    end
  end

  assign tx            = tx_q;
  assign host.full     = full_q;
  assign host.overflow = overflow_q;
  assign host.busy     = (state_q != IDLE) || fifo_nempty;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: two instances (1 and 2 stop bits) decoded tick by tick
// against a byte scoreboard, plus FIFO/overflow/reset/latency checks.
module tb_uart_transmitter;

  localparam int OS = 16;

  logic clk_50m = 1'b0;
  logic rst_n   = 1'b0;
  logic clken   = 1'b0;
  logic a_tx, b_tx;

  uart_transmitter_if a_if();
  uart_transmitter_if b_if();

  uart_transmitter #(.FIFO_DEPTH(4), .OVERSAMPLE(OS), .STOP_BITS(1)) dut_a (
    .clk_50m(clk_50m), .rst_n(rst_n), .clken(clken), .host(a_if.slave), .tx(a_tx));

  uart_transmitter #(.FIFO_DEPTH(4), .OVERSAMPLE(OS), .STOP_BITS(2)) dut_b (
    .clk_50m(clk_50m), .rst_n(rst_n), .clken(clken), .host(b_if.slave), .tx(b_tx));

  always #10 clk_50m = ~clk_50m;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Baud enable: 0 = held low, 1 = every 4 clocks, 2 = random spacing 1..7.
  int ck_mode = 1;
  initial begin
    int ck_wait;
    ck_wait = 1;
    forever begin
      @(negedge clk_50m);
      if (ck_mode == 0) begin
        clken   = 1'b0;
        ck_wait = 1;
      end else if (ck_wait <= 1) begin
        clken   = 1'b1;
        ck_wait = (ck_mode == 1) ? 4 : int'($urandom_range(1, 7));
      end else begin
        clken   = 1'b0;
        ck_wait = ck_wait - 1;
      end
    end
  end

  // ck_d2 high at a negedge means tx now shows the state entered on a clken edge.
  logic ck_d1 = 1'b0, ck_d2 = 1'b0;
  always @(posedge clk_50m) begin
    ck_d1 <= clken;
    ck_d2 <= ck_d1;
  end

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  int         phase[2], scount[2], bitn[2], idle_run[2], last_gap[2], frames[2];
  logic       cur[2];
  logic       bad[2];
  logic [7:0] rbyte[2];

  task automatic rx_reset();
    for (int ch = 0; ch < 2; ch++) begin
      phase[ch] = 0; scount[ch] = 0; bitn[ch] = 0; idle_run[ch] = 0;
      bad[ch] = 1'b0; cur[ch] = 1'b1;
    end
  endtask

  task automatic deliver(input int ch);
    logic [7:0] exp;
    if (ch == 0) begin
      check_eq("frame_timing_a", bad[0], 1'b0);
      check_eq("frame_expected_a", q0.size() != 0, 1'b1);
      if (q0.size() != 0) begin
        exp = q0.pop_front();
        check_eq("byte_a", rbyte[0], exp);
      end
    end else begin
      check_eq("frame_timing_b", bad[1], 1'b0);
      check_eq("frame_expected_b", q1.size() != 0, 1'b1);
      if (q1.size() != 0) begin
        exp = q1.pop_front();
        check_eq("byte_b", rbyte[1], exp);
      end
    end
    frames[ch]++;
    phase[ch]    = 0;
    idle_run[ch] = 0;
  endtask

  // One call per baud tick: start, 8 data bits and stop bits must each span whole OS-tick cells.
  task automatic rx_sample(input int ch, input logic s);
    case (phase[ch])
      0: begin
        if (s == 1'b0) begin
          phase[ch] = 1; scount[ch] = 1; bad[ch] = 1'b0; last_gap[ch] = idle_run[ch];
        end else begin
          idle_run[ch]++;
        end
      end
      1: begin
        if (s !== 1'b0) bad[ch] = 1'b1;
        scount[ch]++;
        if (scount[ch] == OS) begin phase[ch] = 2; scount[ch] = 0; bitn[ch] = 0; end
      end
      2: begin
        if (scount[ch] == 0) cur[ch] = s;
        else if (s !== cur[ch]) bad[ch] = 1'b1;
        scount[ch]++;
        if (scount[ch] == OS) begin
          rbyte[ch][bitn[ch]] = cur[ch];
          bitn[ch]++;
          scount[ch] = 0;
          if (bitn[ch] == 8) phase[ch] = 3;
        end
      end
      default: begin
        if (s !== 1'b1) bad[ch] = 1'b1;
        scount[ch]++;
        if (scount[ch] == OS * (ch + 1)) deliver(ch);
      end
    endcase
  endtask

  initial begin
    rx_reset();
    frames[0] = 0; frames[1] = 0; last_gap[0] = -1; last_gap[1] = -1;
  end

  always @(negedge clk_50m) begin
    if (!rst_n) rx_reset();
    else if (ck_d2) begin
      rx_sample(0, a_tx);
      rx_sample(1, b_tx);
    end
  end

  logic [1:0] prev_tx   = 2'b11;
  int         nonclk_chg = 0;
  bit         glitch_en  = 1'b1;
  always @(negedge clk_50m) begin
    if (glitch_en && rst_n && !ck_d2 && ({b_tx, a_tx} !== prev_tx)) nonclk_chg++;
    prev_tx = {b_tx, a_tx};
  end

  task automatic push(input int ch, input logic [7:0] d, input bit accept);
    @(negedge clk_50m);
    if (ch == 0) begin
      a_if.wr_en = 1'b1; a_if.din = d;
      if (accept) q0.push_back(d);
    end else begin
      b_if.wr_en = 1'b1; b_if.din = d;
      if (accept) q1.push_back(d);
    end
    @(posedge clk_50m);
    #1;
    a_if.wr_en = 1'b0;
    b_if.wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int ch, input int budget);
    for (int c = 0; c < budget; c++) begin
      @(posedge clk_50m);
      #1;
      if (!((ch == 0) ? a_if.busy : b_if.busy)) break;
    end
    if (ch == 0) check_eq("idle_a", a_if.busy, 1'b0);
    else         check_eq("idle_b", b_if.busy, 1'b0);
    repeat (8) @(posedge clk_50m);
  endtask

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, saw, t, lows;
    a_if.wr_en = 1'b0; a_if.din = '0;
    b_if.wr_en = 1'b0; b_if.din = '0;

    repeat (3) @(posedge clk_50m);
    #1;
    check_eq("rst_tx_a", a_tx, 1'b1);
    check_eq("rst_busy_a", a_if.busy, 1'b0);
    check_eq("rst_full_a", a_if.full, 1'b0);
    check_eq("rst_ovf_a", a_if.overflow, 1'b0);
    check_eq("rst_tx_b", b_tx, 1'b1);
    check_eq("rst_busy_b", b_if.busy, 1'b0);
    check_eq("rst_full_b", b_if.full, 1'b0);
    check_eq("rst_ovf_b", b_if.overflow, 1'b0);
    @(negedge clk_50m);
    rst_n = 1'b1;
    repeat (4) @(posedge clk_50m);

    // Single 0x55: tx falls one clock after the first clken edge, busy spans that edge + 160 ticks.
    ck_mode = 1;
    push(0, 8'h55, 1'b1);
    n = 0; saw = 0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk_50m);
      #1;
      if (saw == 1) begin check_eq("start_latency", a_tx, 1'b0); saw = 2; end
      if (ck_d1) begin n++; if (saw == 0) saw = 1; end
      if (!a_if.busy) break;
    end
    check_eq("busy_ticks", n, 161);
    check_eq("busy_low", a_if.busy, 1'b0);
    repeat (8) @(posedge clk_50m);
    check_eq("frames_1", frames[0], 1);
    check_eq("sb_drained_1", q0.size(), 0);

    // Back-to-back frames.
    push(0, 8'hA5, 1'b1);
    push(0, 8'h3C, 1'b1);
    wait_idle(0, 5000);
    check_eq("b2b_gap", last_gap[0], 0);
    check_eq("frames_2", frames[0], 3);
    check_eq("sb_drained_2", q0.size(), 0);

    // Overflow with the baud enable held off.
    ck_mode = 0;
    repeat (3) @(posedge clk_50m);
    for (int i = 1; i <= 5; i++) begin
      push(0, 8'(i), i <= 4);
      check_eq("full_after_wr", a_if.full, i >= 4);
      check_eq("ovf_after_wr", a_if.overflow, i == 5);
    end
    @(posedge clk_50m);
    #1;
    check_eq("ovf_one_cycle", a_if.overflow, 1'b0);
    check_eq("full_held", a_if.full, 1'b1);
    ck_mode = 1;
    wait_idle(0, 6000);
    check_eq("frames_3", frames[0], 7);
    check_eq("sb_drained_3", q0.size(), 0);

    // Two stop bits: 0x00 keeps the line low 9 cells, next start follows 2 stop cells.
    push(1, 8'h00, 1'b1);
    push(1, 8'h81, 1'b1);
    wait_idle(1, 6000);
    check_eq("sb2_gap", last_gap[1], 0);
    check_eq("frames_b", frames[1], 2);
    check_eq("sb_drained_b", q1.size(), 0);

    // Irregular baud enable spacing.
    ck_mode = 2;
    push(0, 8'h96, 1'b1);
    wait_idle(0, 8000);
    check_eq("frames_4", frames[0], 8);
    check_eq("sb_drained_4", q0.size(), 0);
    check_eq("nonclk_tx_change", nonclk_chg, 0);

    // Reset in the middle of bit 3 of 0xF0 with two bytes still queued.
    ck_mode = 1;
    push(0, 8'hF0, 1'b1);
    push(0, 8'h11, 1'b1);
    push(0, 8'h22, 1'b1);
    for (int c = 0; c < 200; c++) begin
      @(posedge clk_50m);
      #1;
      if (!a_tx) break;
    end
    check_eq("frame_started", a_tx, 1'b0);
    t = 0;
    for (int c = 0; c < 2000 && t < 72; c++) begin
      @(posedge clk_50m);
      #1;
      if (ck_d1) t++;
    end
    check_eq("reached_bit3", t, 72);
    @(negedge clk_50m);
    #2;
    check_eq("tx_bit3_low", a_tx, 1'b0);
    glitch_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_tx", a_tx, 1'b1);
    check_eq("mid_rst_busy", a_if.busy, 1'b0);
    check_eq("mid_rst_full", a_if.full, 1'b0);
    q0.delete();
    repeat (3) @(posedge clk_50m);
    @(negedge clk_50m);
    rst_n = 1'b1;
    glitch_en = 1'b1;
    lows = 0;
    repeat (800) begin
      @(negedge clk_50m);
      if (!a_tx) lows++;
    end
    check_eq("post_rst_tx_low_count", lows, 0);
    check_eq("post_rst_busy", a_if.busy, 1'b0);
    check_eq("post_rst_frames", frames[0], 8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- 8N1 (or 8N2) UART transmitter with a small write FIFO. It is the transmit-side counterpart of the team's UART receiver.
- Shares the same 16x-oversampled baud enable (`clken`) from the common baud generator. One bit period is OVERSAMPLE `clken` ticks.
- Host logic pushes bytes into the FIFO. The block serializes them LSB first on `tx`, back-to-back, with no idle gap while data remains.

Parameters:
- FIFO_DEPTH, 4: entries in the write FIFO. Power of two, >=2.
- OVERSAMPLE, 16: `clken` ticks per bit period. Range 4..16.
- STOP_BITS, 1: stop bits per frame. 1 or 2.

Ports:
- clk_50m  in   1  system clock. All logic on its rising edge.
- rst_n    in   1  asynchronous active-low reset.
- clken    in   1  one-cycle baud enable pulse at OVERSAMPLE x baud rate.
- wr_en    in   1  write strobe. Pushes `din` when accepted.
- din      in   8  byte to transmit.
- full     out  1  FIFO full. Registered.
- overflow out  1  one-cycle pulse when `wr_en` arrives while `full`=1.
- busy     out  1  high while a frame is on the line or the FIFO is non-empty.
- tx       out  1  serial line, idle high. Registered, glitch-free.

Behaviour:
- Reset (async assert, sync release):
  - tx=1, busy=0, full=0, overflow=0.
  - FIFO count=0, rd/wr pointers=0.
  - FSM=IDLE, tick counter=0, bitpos=0, shift register=0.
- Reset mid-frame: tx returns high immediately; the partial frame and all FIFO contents are discarded.
- FIFO:
  - Pointer width clog2(FIFO_DEPTH); count width clog2(FIFO_DEPTH)+1.
  - Pointers wrap modulo FIFO_DEPTH.
  - Write accepted iff wr_en && !full, using the registered `full` from the previous edge.
  - Write when full: data dropped, FIFO unchanged, overflow=1 for exactly that cycle.
  - Simultaneous accepted write and pop: count unchanged, both pointers advance.
  - full = (count==FIFO_DEPTH), updated on the same edge as count.
- Tick counter: 4 bits. Advances only on cycles with clken=1. When clken=0 the FSM and counter hold.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1.
  - On a clken cycle with FIFO non-empty: pop the head into the shift register, counter=0, go to START.
- START:
  - tx=0.
  - On each clken the counter increments.
  - On the clken where counter==OVERSAMPLE-1: counter=0, bitpos=0, go to DATA.
- DATA:
  - tx=shift[0].
  - On the clken where counter==OVERSAMPLE-1: shift right by 1, bitpos+1, counter=0.
  - After bitpos 7 completes, go to STOP with stop-bit index=0.
- STOP:
  - tx=1 for STOP_BITS x OVERSAMPLE ticks.
  - At the end: if FIFO non-empty, pop and go directly to START (no idle bit); otherwise go to IDLE.
- tx is driven from a registered copy of the state and data bit. A change in state is visible on tx one clk_50m cycle after the deciding edge.
- Frame length: (1+8+STOP_BITS) x OVERSAMPLE clken ticks.
  - 160 ticks for the defaults.
  - 176 ticks for STOP_BITS=2.
- Latency: byte written at edge N into an empty FIFO with FSM IDLE → tx falls one cycle after the first clken edge at or after N+1.
- busy = (FSM != IDLE) || (count != 0). Goes high the cycle after an accepted write, low the cycle after entering IDLE with an empty FIFO.
- wr_en during an active frame is legal. Pops happen only at frame boundaries.
- din is sampled only on accepted writes.

Test Plan:
- Single byte 0x55, clken every 4 clocks → tx: start 0, then 1,0,1,0,1,0,1,0 (LSB first), stop 1. Each bit 16 ticks (64 clocks); busy falls after 160 ticks.
- Back-to-back 0xA5 then 0x3C written on consecutive cycles → two frames with no gap; the second start bit begins the tick after the first stop bit ends. Decoded bytes are 0xA5, 0x3C.
- Overflow: clken held low, write 0x01..0x05 on 5 consecutive cycles → full=1 after the 4th write; overflow pulses once on the 5th. Release clken → only 0x01..0x04 transmitted.
- Reset mid-frame: assert rst_n=0 during bit 3 of 0xF0 with 2 bytes queued → tx=1 asynchronously, busy=0, full=0. After release, tx stays 1 with no further frames.
- STOP_BITS=2, byte 0x00 → tx low for 9x16 ticks, then high for 32 ticks before the next queued start bit.
- clken gaps: randomized clken spacing (1–7 clocks) for 0x96 → bit durations are exactly 16 clken ticks each, and tx never changes on a non-clken edge.
